// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD SPI command framer.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_RX,
        ST_POLL,
        ST_POLL_RX,
        ST_DONE
    } sd_state_t;

    localparam logic [6:0] CRC7_POLY     = 7'h09;
    localparam logic [7:0] FILL_BYTE     = 8'hFF;
    localparam logic [1:0] START_PREFIX  = 2'b01;
    localparam logic [7:0] CRC_BYTE_CMD0 = 8'h95;
    localparam logic [7:0] CRC_BYTE_CMD8 = 8'h87;
    localparam logic [2:0] FRAME_LAST    = 3'd5;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    // Closing byte used when CRC generation is compiled out; only CMD0/CMD8
    // are CRC-checked by the card before CRC checking is switched off.
    function automatic logic [7:0] fixed_crc_byte(input logic [5:0] idx);
        case (idx)
            CMD0:    fixed_crc_byte = CRC_BYTE_CMD0;
            CMD8:    fixed_crc_byte = CRC_BYTE_CMD8;
            default: fixed_crc_byte = FILL_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Byte channel between the command framer and the SPI byte controller.
interface sd_cmd_framer_if;
    logic       TX_STB;
    logic [7:0] TX_DATA;
    logic       TX_ACK;
    logic       RX_STB;
    logic [7:0] RX_DATA;

    modport master (output TX_STB, TX_DATA, input TX_ACK, RX_STB, RX_DATA);
    modport slave  (input TX_STB, TX_DATA, output TX_ACK, RX_STB, RX_DATA);
endinterface

// File: rtl/sd_cmd_framer_crc7.sv
// Combinational byte-wide CRC7 update (x^7 + x^3 + 1), MSB first.
module sd_crc7
    import sd_pkg::*;
(
    input  logic [6:0] crc_in,
    input  logic [7:0] data_byte,
    output logic [6:0] crc_out
);

    logic [6:0] c;
    logic [7:0] d;
    logic       fb;

    always_comb begin
        c  = crc_in;
        d  = data_byte;
        fb = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[6] ^ d[7];
            c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
            d  = {d[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/sd_cmd_framer.sv
// SD SPI command framer: sends the 6-byte command frame, polls for R1.
// SD_CRC7_EN defined: CRC7 computed per command; undefined: fixed CRC table.
module sd_cmd_framer
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MAX = 8
) (
    input  logic                   CLOCK50,
    input  logic                   RESET,
    input  logic                   CMD_STB,
    input  logic [5:0]             CMD_IDX,
    input  logic [31:0]            CMD_ARG,
    output logic                   CMD_ACK,
    output logic                   BUSY,
    sd_cmd_framer_if.master        spi,
    output logic                   R1_STB,
    output logic [7:0]             R1_DATA,
    output logic                   R1_TIMEOUT
);

    if (NCR_MAX < 1 || NCR_MAX > 255) begin : g_ncr_check
        $error("NCR_MAX must be in 1..255");
    end

    localparam logic [7:0] NCR_LAST = NCR_MAX[7:0];

    sd_state_t   state, state_n;
    logic [5:0]  idx_q, idx_n;
    logic [31:0] arg_q, arg_n;
    logic [2:0]  byte_idx, byte_n;
    logic [7:0]  poll_cnt, poll_n;
    logic        ack_n, busy_n, stb_n, r1_stb_n, tmo_n;
    logic [7:0]  tx_data_q, data_n, r1_data_n;
    logic        tx_stb_q;
    logic [7:0]  crc_byte, frame_byte;

`ifdef SD_CRC7_EN
    logic [6:0] crc_q, crc_next;

    sd_crc7 u_crc7 (
        .crc_in    (crc_q),
        .data_byte (tx_data_q),
        .crc_out   (crc_next)
    );

    // Accumulates over b0..b4 as each is accepted; complete before b5 is built.
    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            crc_q <= '0;
        end else if (state == ST_IDLE && CMD_STB) begin
            crc_q <= '0;
        end else if (state == ST_SEND && tx_stb_q && spi.TX_ACK) begin
            crc_q <= crc_next;
        end
    end

    assign crc_byte = {crc_q, 1'b1};
`else
    assign crc_byte = fixed_crc_byte(idx_q);
`endif

    always_comb begin
        case (byte_idx)
            3'd0:    frame_byte = {START_PREFIX, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            default: frame_byte = crc_byte;
        endcase
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx_q;
        arg_n     = arg_q;
        byte_n    = byte_idx;
        poll_n    = poll_cnt;
        ack_n     = 1'b0;
        busy_n    = BUSY;
        stb_n     = tx_stb_q;
        data_n    = tx_data_q;
        r1_stb_n  = 1'b0;
        r1_data_n = R1_DATA;
        tmo_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (CMD_STB) begin
                    idx_n     = CMD_IDX;
                    arg_n     = CMD_ARG;
                    ack_n     = 1'b1;
                    busy_n    = 1'b1;
                    r1_data_n = '0;
                    byte_n    = '0;
                    state_n   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_stb_q && spi.TX_ACK) begin
                    stb_n   = 1'b0;
                    state_n = ST_SEND_RX;
                end else begin
                    stb_n  = 1'b1;
                    data_n = frame_byte;
                end
            end
            ST_SEND_RX: begin
                if (spi.RX_STB) begin
                    if (byte_idx == FRAME_LAST) begin
                        poll_n  = '0;
                        state_n = ST_POLL;
                    end else begin
                        byte_n  = byte_idx + 3'd1;
                        state_n = ST_SEND;
                    end
                end
            end
            ST_POLL: begin
                if (tx_stb_q && spi.TX_ACK) begin
                    stb_n   = 1'b0;
                    state_n = ST_POLL_RX;
                end else begin
                    stb_n  = 1'b1;
                    data_n = FILL_BYTE;
                end
            end
            ST_POLL_RX: begin
                if (spi.RX_STB) begin
                    poll_n = poll_cnt + 8'd1;
                    if (!spi.RX_DATA[7]) begin
                        r1_data_n = spi.RX_DATA;
                        r1_stb_n  = 1'b1;
                        state_n   = ST_DONE;
                    end else if (poll_n == NCR_LAST) begin
                        tmo_n   = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_POLL;
                    end
                end
            end
            ST_DONE: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            idx_q      <= '0;
            arg_q      <= '0;
            byte_idx   <= '0;
            poll_cnt   <= '0;
            CMD_ACK    <= 1'b0;
            BUSY       <= 1'b0;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= FILL_BYTE;
            R1_STB     <= 1'b0;
            R1_DATA    <= '0;
            R1_TIMEOUT <= 1'b0;
        end else begin
            state      <= state_n;
            idx_q      <= idx_n;
            arg_q      <= arg_n;
            byte_idx   <= byte_n;
            poll_cnt   <= poll_n;
            CMD_ACK    <= ack_n;
            BUSY       <= busy_n;
            tx_stb_q   <= stb_n;
            tx_data_q  <= data_n;
            R1_STB     <= r1_stb_n;
            R1_DATA    <= r1_data_n;
            R1_TIMEOUT <= tmo_n;
        end
    end

    assign spi.TX_STB  = tx_stb_q;
    assign spi.TX_DATA = tx_data_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Self-checking bench for sd_cmd_framer with a behavioural SPI byte controller.
`timescale 1ns/1ps
module tb_sd_cmd_framer;

    localparam int unsigned NCR = 8;

    logic        CLOCK50 = 1'b0;
    logic        RESET;
    logic        CMD_STB;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    logic        CMD_ACK, BUSY, R1_STB, R1_TIMEOUT;
    logic [7:0]  R1_DATA;

    sd_cmd_framer_if spi ();

    sd_cmd_framer #(.NCR_MAX(NCR)) dut (
        .CLOCK50    (CLOCK50),
        .RESET      (RESET),
        .CMD_STB    (CMD_STB),
        .CMD_IDX    (CMD_IDX),
        .CMD_ARG    (CMD_ARG),
        .CMD_ACK    (CMD_ACK),
        .BUSY       (BUSY),
        .spi        (spi),
        .R1_STB     (R1_STB),
        .R1_DATA    (R1_DATA),
        .R1_TIMEOUT (R1_TIMEOUT)
    );

    always #10 CLOCK50 = ~CLOCK50;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_q[$];
    int unsigned byte_cnt = 0;
    int          ack_cnt = 0, r1_cnt = 0, tmo_cnt = 0;

    // SPI controller model: acks each byte, answers two cycles later.
    // Frame bytes get 0xFF back; fill bytes take the scripted response queue.
    initial begin : spi_model
        logic [7:0] got, expv, rsp;
        spi.TX_ACK  = 1'b0;
        spi.RX_STB  = 1'b0;
        spi.RX_DATA = 8'hFF;
        forever begin
            @(posedge CLOCK50); #1;
            if (!RESET && spi.TX_STB) begin
                got = spi.TX_DATA;
                byte_cnt++;
                checks++;
                if (tx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h, required no byte", got);
                end else begin
                    expv = tx_exp_q.pop_front();
                    if (got !== expv) begin
                        errors++;
                        $display("FAIL tx_byte[%0d]: got %02h, required %02h", byte_cnt - 1, got, expv);
                    end
                end
                spi.TX_ACK = 1'b1;
                @(posedge CLOCK50); #1;
                spi.TX_ACK = 1'b0;
                repeat (2) begin @(posedge CLOCK50); #1; end
                rsp = (byte_cnt > 6 && rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                spi.RX_DATA = rsp;
                spi.RX_STB  = 1'b1;
                @(posedge CLOCK50); #1;
                spi.RX_STB  = 1'b0;
                spi.RX_DATA = 8'hFF;
            end
        end
    end

    always @(negedge CLOCK50) begin
        if (CMD_ACK)    ack_cnt++;
        if (R1_STB)     r1_cnt++;
        if (R1_TIMEOUT) tmo_cnt++;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [7:0] b5, input int unsigned polls);
        logic [7:0] b0;
        b0 = {2'b01, idx};
        tx_exp_q.push_back(b0);
        tx_exp_q.push_back(arg[31:24]);
        tx_exp_q.push_back(arg[23:16]);
        tx_exp_q.push_back(arg[15:8]);
        tx_exp_q.push_back(arg[7:0]);
        tx_exp_q.push_back(b5);
        for (int unsigned i = 0; i < polls; i++) tx_exp_q.push_back(8'hFF);
        byte_cnt = 0;
        @(negedge CLOCK50);
        CMD_IDX = idx; CMD_ARG = arg; CMD_STB = 1'b1;
        @(negedge CLOCK50);
        CMD_STB = 1'b0; CMD_IDX = '0; CMD_ARG = '0;
        checks++;
        if (CMD_ACK !== 1'b1) begin errors++; $display("FAIL cmd_ack: got %b, required 1", CMD_ACK); end
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b, required 1", BUSY); end
        checks++;
        if (R1_DATA !== 8'h00) begin errors++; $display("FAIL r1_clear: got %02h, required 00", R1_DATA); end
        @(negedge CLOCK50);
        checks++;
        if (CMD_ACK !== 1'b0 || spi.TX_STB !== 1'b1 || spi.TX_DATA !== b0) begin
            errors++;
            $display("FAIL first_byte: ack=%b stb=%b data=%02h, required ack=0 stb=1 data=%02h",
                     CMD_ACK, spi.TX_STB, spi.TX_DATA, b0);
        end
    endtask

    task automatic wait_done(input logic exp_tmo, input logic [7:0] exp_r1);
        int unsigned n;
        n = 0;
        do begin @(negedge CLOCK50); n++; end while (!(R1_STB || R1_TIMEOUT) && n < 400);
        checks++;
        if (!(R1_STB || R1_TIMEOUT)) begin
            errors++;
            $display("FAIL done_wait: no R1_STB/R1_TIMEOUT within 400 cycles, required one");
        end
        checks++;
        if (R1_STB !== !exp_tmo || R1_TIMEOUT !== exp_tmo) begin
            errors++;
            $display("FAIL result_kind: r1_stb=%b timeout=%b, required r1_stb=%b timeout=%b",
                     R1_STB, R1_TIMEOUT, !exp_tmo, exp_tmo);
        end
        checks++;
        if (R1_DATA !== exp_r1) begin errors++; $display("FAIL r1_data: got %02h, required %02h", R1_DATA, exp_r1); end
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_hold: got %b, required 1", BUSY); end
        @(negedge CLOCK50);
        checks++;
        if (BUSY !== 1'b0 || R1_STB !== 1'b0 || R1_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy=%b r1_stb=%b timeout=%b, required 0 0 0", BUSY, R1_STB, R1_TIMEOUT);
        end
        checks++;
        if (tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL bytes_left: got %0d unsent, required 0", tx_exp_q.size());
        end
        repeat (4) @(negedge CLOCK50);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK50);
        checks++;
        if (CMD_ACK !== 1'b0 || BUSY !== 1'b0 || spi.TX_STB !== 1'b0 || R1_STB !== 1'b0 || R1_TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b busy=%b stb=%b r1=%b tmo=%b, required all 0",
                     CMD_ACK, BUSY, spi.TX_STB, R1_STB, R1_TIMEOUT);
        end
        checks++;
        if (spi.TX_DATA !== 8'hFF) begin errors++; $display("FAIL reset_txdata: got %02h, required ff", spi.TX_DATA); end
        checks++;
        if (R1_DATA !== 8'h00) begin errors++; $display("FAIL reset_r1data: got %02h, required 00", R1_DATA); end
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK50);
    endtask

    task automatic test_cmd0();
        rx_q.push_back(8'hFF); rx_q.push_back(8'hFF); rx_q.push_back(8'h01);
        issue_cmd(6'd0, 32'h0, 8'h95, 3);
        wait_done(1'b0, 8'h01);
    endtask

    task automatic test_cmd8();
        rx_q.push_back(8'h01);
        issue_cmd(6'd8, 32'h0000_01AA, 8'h87, 1);
        wait_done(1'b0, 8'h01);
    endtask

    task automatic test_cmd17();
        logic [7:0] b5;
`ifdef SD_CRC7_EN
        b5 = 8'h55;
`else
        b5 = 8'hFF;
`endif
        rx_q.push_back(8'hFF); rx_q.push_back(8'h00);
        issue_cmd(6'd17, 32'h0, b5, 2);
        wait_done(1'b0, 8'h00);
    endtask

    task automatic test_timeout();
        logic [7:0] b5;
        int r0, t0;
`ifdef SD_CRC7_EN
        b5 = 8'h65;
`else
        b5 = 8'hFF;
`endif
        #1; r0 = r1_cnt; t0 = tmo_cnt;
        issue_cmd(6'd55, 32'h0, b5, NCR);
        wait_done(1'b1, 8'h00);
        #1;
        checks++;
        if (tmo_cnt - t0 != 1 || r1_cnt - r0 != 0) begin
            errors++;
            $display("FAIL timeout_pulses: tmo=%0d r1=%0d, required tmo=1 r1=0", tmo_cnt - t0, r1_cnt - r0);
        end
    endtask

    task automatic test_busy_ignored();
        int a0;
        rx_q.push_back(8'hFF); rx_q.push_back(8'h05);
        issue_cmd(6'd8, 32'h0000_01AA, 8'h87, 2);
        #1; a0 = ack_cnt;
        repeat (7) @(negedge CLOCK50);
        CMD_IDX = 6'd17; CMD_ARG = 32'hDEAD_BEEF; CMD_STB = 1'b1;
        @(negedge CLOCK50);
        CMD_STB = 1'b0; CMD_IDX = '0; CMD_ARG = '0;
        wait_done(1'b0, 8'h05);
        #1;
        checks++;
        if (ack_cnt != a0) begin errors++; $display("FAIL busy_ack: got %0d acks, required 0", ack_cnt - a0); end
    endtask

    task automatic test_reset_midframe();
        int unsigned n;
        int r0, t0;
        issue_cmd(6'd0, 32'h0, 8'h95, 1);
        n = 0;
        while (byte_cnt < 3 && n < 200) begin @(posedge CLOCK50); #2; n++; end
        checks++;
        if (byte_cnt < 3) begin errors++; $display("FAIL midframe_wait: got %0d bytes, required 3", byte_cnt); end
        @(posedge CLOCK50); #2;
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b, required 1", BUSY); end
        r0 = r1_cnt; t0 = tmo_cnt;
        RESET = 1'b1;
        #1;
        checks++;
        if (spi.TX_STB !== 1'b0 || BUSY !== 1'b0 || CMD_ACK !== 1'b0 || spi.TX_DATA !== 8'hFF || R1_DATA !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: stb=%b busy=%b ack=%b txd=%02h r1d=%02h, required 0 0 0 ff 00",
                     spi.TX_STB, BUSY, CMD_ACK, spi.TX_DATA, R1_DATA);
        end
        repeat (10) @(negedge CLOCK50);
        tx_exp_q.delete();
        rx_q.delete();
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK50);
        #1;
        checks++;
        if (r1_cnt != r0 || tmo_cnt != t0 || spi.TX_STB !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: r1=%0d tmo=%0d stb=%b, required 0 0 0", r1_cnt - r0, tmo_cnt - t0, spi.TX_STB);
        end
        rx_q.push_back(8'h01);
        issue_cmd(6'd0, 32'h0, 8'h95, 1);
        wait_done(1'b0, 8'h01);
    endtask

    initial begin
        RESET = 1'b1; CMD_STB = 1'b0; CMD_IDX = '0; CMD_ARG = '0;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd17();
        test_timeout();
        test_busy_ignored();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
